// File: rtl/result_bcd_formatter.sv
// Buffers signed 7-bit results in a small FIFO and converts each one to sign plus two BCD digits.
// Optional sticky drop flag port "ovf" is built when OVF_FLAG_EN is defined.
module result_bcd_formatter #(
    parameter int DEPTH  = 4,
    parameter int SHIFTS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] in_result,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_sign,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones
`ifdef OVF_FLAG_EN
    ,
    output logic       ovf
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ITER_W = $clog2(SHIFTS + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(SHIFTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT r_state;
    stateT w_nextState;

    logic [6:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic              r_signR;
    logic [6:0]        r_mag;
    logic [7:0]        r_bcd;
    logic [ITER_W-1:0] r_iter;

    logic       r_outValid;
    logic       r_outSign;
    logic [3:0] r_outTens;
    logic [3:0] r_outOnes;

    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic       w_shift;
    logic       w_finish;
    logic       w_ack;
    logic [6:0] w_head;
    logic [6:0] w_headMag;
    logic [3:0] w_tensAdj;
    logic [3:0] w_onesAdj;
    logic [7:0] w_bcdNext;
    logic [6:0] w_magNext;

    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign w_full    = (r_count == FULL_CNT);
    assign w_push    = in_valid && (!w_full || w_pop);
    assign w_head    = r_mem[r_rdPtr];
    assign w_headMag = w_head[6] ? (~w_head + 7'd1) : w_head;

    assign w_tensAdj = (r_bcd[7:4] >= 4'd5) ? (r_bcd[7:4] + 4'd3) : r_bcd[7:4];
    assign w_onesAdj = (r_bcd[3:0] >= 4'd5) ? (r_bcd[3:0] + 4'd3) : r_bcd[3:0];
    assign {w_bcdNext, w_magNext} = {w_tensAdj, w_onesAdj, r_mag} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_iter == LAST_ITER) begin
                    w_finish    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (r_outValid && out_ready) begin
                    w_ack       = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The final iteration loads the display registers straight from the shifted BCD value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signR    <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_outValid <= 1'b0;
            r_outSign  <= 1'b0;
            r_outTens  <= '0;
            r_outOnes  <= '0;
        end else begin
            if (w_pop) begin
                r_signR <= w_head[6];
                r_mag   <= w_headMag;
                r_bcd   <= '0;
                r_iter  <= '0;
            end
            if (w_shift) begin
                r_bcd  <= w_bcdNext;
                r_mag  <= w_magNext;
                r_iter <= r_iter + 1'b1;
            end
            if (w_finish) begin
                r_outValid <= 1'b1;
                r_outSign  <= r_signR;
                r_outTens  <= w_bcdNext[7:4];
                r_outOnes  <= w_bcdNext[3:0];
            end
            if (w_ack) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_sign  = r_outSign;
    assign out_tens  = r_outTens;
    assign out_ones  = r_outOnes;

`ifdef OVF_FLAG_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop = in_valid && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
